// File: rtl/count_reg.sv
// count_reg: state stage of the 16-bit loadable down-counter.
// Holds the count and the reload period, and accepts new periods over a
// valid/ready load port. It decrements while enabled and, on expiry, emits a
// one-cycle terminal-count pulse. It then either reloads the period or returns
// to IDLE, depending on AUTO_RELOAD.
module count_reg #(
    parameter int WIDTH       = 16,
    parameter bit AUTO_RELOAD = 1'b1,
    parameter int EXP_W       = 8
) (
    input  logic             clk_pad,
    input  logic             rst_pad,
    input  logic             clear_pad,
    input  logic             load_valid_pad,
    input  logic [WIDTH-1:0] load_data_pad,
    output logic             load_ready_pad,
    input  logic             enable_pad,
    output logic [WIDTH-1:0] count_pad,
    output logic             busy_pad,
    output logic             tc_pulse_pad,
    output logic [EXP_W-1:0] exp_count_pad
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             tc_q, tc_d;

    logic             load_ready;
    logic             load_fire;
    logic             expire_hit;

    // Expiry counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [EXP_W-1:0] sat_inc(input logic [EXP_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + EXP_ONE;
    endfunction

    // Ready is low while clearing and during the single EXPIRE cycle, so a
    // load can never collide with the reload or the clear.
    assign load_ready = ~clear_pad & (state_q != EXPIRE);
    assign load_fire  = load_valid_pad & load_ready;
    assign expire_hit = (state_q == RUN) & enable_pad & (count_q == CNT_ONE);

    // State register plus datapath registers; reset returns everything to zero.
    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= '0;
            exp_q    <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            exp_q    <= exp_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state logic: clear, then load, then count/expiry sequencing.
    always_comb begin
        state_d = state_q;
        if (clear_pad) begin
            state_d = IDLE;
        end else if (load_fire) begin
            state_d = (load_data_pad != CNT_ZERO) ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = expire_hit ? EXPIRE : RUN;
                EXPIRE:  state_d = AUTO_RELOAD ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: count, stored period, expiry count and tc strobe.
    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        exp_d    = exp_q;
        tc_d     = 1'b0;
        if (clear_pad) begin
            count_d  = '0;
            period_d = '0;
            exp_d    = '0;
        end else if (load_fire) begin
            count_d  = load_data_pad;
            period_d = load_data_pad;
            exp_d    = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (expire_hit) begin
                        count_d = '0;
                        exp_d   = sat_inc(exp_q);
                        tc_d    = 1'b1;
                    end else if (enable_pad) begin
                        count_d = count_q - CNT_ONE;
                    end
                end
                EXPIRE: begin
                    count_d = AUTO_RELOAD ? period_q : CNT_ZERO;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Output logic: busy while counting or expiring, registered values straight out.
    always_comb begin
        load_ready_pad = load_ready;
        busy_pad       = (state_q == RUN) || (state_q == EXPIRE);
        count_pad      = count_q;
        tc_pulse_pad   = tc_q;
        exp_count_pad  = exp_q;
    end

endmodule

// File: tb/tb_count_reg.sv
// Directed testbench for count_reg. It uses one auto-reload instance and one
// run-once instance, each with its own stimulus signals.
module tb_count_reg;

    localparam int WIDTH = 16;
    localparam int EXP_W = 8;

    logic             clk;
    int               vectors;
    int               miscompares;

    // auto-reload instance signals
    logic             rst, clear, valid, enable;
    logic [WIDTH-1:0] data;
    logic             ready, busy, tc;
    logic [WIDTH-1:0] count;
    logic [EXP_W-1:0] expc;

    // run-once instance signals
    logic             n_rst, n_clear, n_valid, n_enable;
    logic [WIDTH-1:0] n_data;
    logic             n_ready, n_busy, n_tc;
    logic [WIDTH-1:0] n_count;
    logic [EXP_W-1:0] n_expc;

    count_reg #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b1), .EXP_W(EXP_W)) u_ar (
        .clk_pad        (clk),
        .rst_pad        (rst),
        .clear_pad      (clear),
        .load_valid_pad (valid),
        .load_data_pad  (data),
        .load_ready_pad (ready),
        .enable_pad     (enable),
        .count_pad      (count),
        .busy_pad       (busy),
        .tc_pulse_pad   (tc),
        .exp_count_pad  (expc)
    );

    count_reg #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b0), .EXP_W(EXP_W)) u_nr (
        .clk_pad        (clk),
        .rst_pad        (n_rst),
        .clear_pad      (n_clear),
        .load_valid_pad (n_valid),
        .load_data_pad  (n_data),
        .load_ready_pad (n_ready),
        .enable_pad     (n_enable),
        .count_pad      (n_count),
        .busy_pad       (n_busy),
        .tc_pulse_pad   (n_tc),
        .exp_count_pad  (n_expc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // state checker for the auto-reload instance
    task automatic chk_ar(input string tag, input logic [15:0] c, input logic b,
                          input logic t, input logic [7:0] e);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".exp"},   32'(expc),  32'(e));
    endtask

    // expected sequence after loading 5 with enable held high
    logic [15:0] seq_cnt [12] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd5,
                                  16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd5};
    logic        seq_tc  [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    logic [7:0]  seq_exp [12] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1,
                                  8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1; clear = 0; valid = 0; enable = 0; data = '0;
        n_rst = 1; n_clear = 0; n_valid = 0; n_enable = 0; n_data = '0;

        // reset state
        tick(); tick();
        rst = 0;
        chk_ar("reset", 16'd0, 1'b0, 1'b0, 8'd0);
        chk("reset.ready", 32'(ready), 32'd1);

        // load 5, auto-reload, enable held high
        valid = 1; data = 16'd5; enable = 1;
        #1 chk("load5.ready", 32'(ready), 32'd1);
        tick();
        valid = 0;
        chk_ar("load5", 16'd5, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_ar($sformatf("ar.step%0d", i), seq_cnt[i], 1'b1, seq_tc[i], seq_exp[i]);
        end

        // load held valid during EXPIRE waits one cycle
        for (int i = 0; i < 4; i++) tick();     // 4,3,2,1
        tick();                                 // EXPIRE
        chk_ar("exp3", 16'd0, 1'b1, 1'b1, 8'd3);
        valid = 1; data = 16'd7;
        #1 chk("expire.ready", 32'(ready), 32'd0);
        tick();
        chk_ar("reload_not_load", 16'd5, 1'b1, 1'b0, 8'd3);
        chk("post_expire.ready", 32'(ready), 32'd1);
        tick();
        valid = 0;
        chk_ar("load7", 16'd7, 1'b1, 1'b0, 8'd0);

        // enable toggling with a load of 4
        valid = 1; data = 16'd4; enable = 0;
        tick();
        valid = 0;
        chk_ar("load4", 16'd4, 1'b1, 1'b0, 8'd0);
        enable = 1; tick(); chk_ar("tog1", 16'd3, 1'b1, 1'b0, 8'd0);
        enable = 0; tick(); chk_ar("tog0", 16'd3, 1'b1, 1'b0, 8'd0);
        enable = 1; tick(); chk_ar("tog1b", 16'd2, 1'b1, 1'b0, 8'd0);
        enable = 0; tick(); chk_ar("tog0b", 16'd2, 1'b1, 1'b0, 8'd0);

        // clear at count 2 with a pending load
        clear = 1; valid = 1; data = 16'd9; enable = 1;
        #1 chk("clear.ready", 32'(ready), 32'd0);
        tick();
        clear = 0; valid = 0;
        chk_ar("clear", 16'd0, 1'b0, 1'b0, 8'd0);
        tick(); chk_ar("clear_idle1", 16'd0, 1'b0, 1'b0, 8'd0);
        tick(); chk_ar("clear_idle2", 16'd0, 1'b0, 1'b0, 8'd0);

        // load in the same cycle as count==1 expiry wins
        valid = 1; data = 16'd2;
        tick(); valid = 0;
        chk_ar("load2", 16'd2, 1'b1, 1'b0, 8'd0);
        tick(); chk_ar("cnt1", 16'd1, 1'b1, 1'b0, 8'd0);
        valid = 1; data = 16'd3;
        tick(); valid = 0;
        chk_ar("load_over_expiry", 16'd3, 1'b1, 1'b0, 8'd0);

        // reset mid-RUN
        tick();
        rst = 1; tick(); rst = 0;
        chk_ar("rst_mid_run", 16'd0, 1'b0, 1'b0, 8'd0);
        tick(); chk_ar("rst_idle", 16'd0, 1'b0, 1'b0, 8'd0);

        // longest period, no overflow
        valid = 1; data = 16'hFFFF;
        tick(); valid = 0;
        chk_ar("loadFFFF", 16'hFFFF, 1'b1, 1'b0, 8'd0);
        tick(); chk_ar("FFFE", 16'hFFFE, 1'b1, 1'b0, 8'd0);

        // 300 expiries with load 1: exp saturates at 255
        valid = 1; data = 16'd1;
        tick(); valid = 0;
        chk_ar("load1", 16'd1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 0) chk_ar("sat.first", 16'd0, 1'b1, 1'b1, 8'd1);
            tick();
        end
        chk_ar("sat.final", 16'd1, 1'b1, 1'b0, 8'd255);
        valid = 1; data = 16'd0;
        tick(); valid = 0;
        chk_ar("load0", 16'd0, 1'b0, 1'b0, 8'd0);
        tick(); chk_ar("load0_idle", 16'd0, 1'b0, 1'b0, 8'd0);

        // run-once instance: load 3, expire once, back to IDLE
        n_rst = 0;
        n_valid = 1; n_data = 16'd3; n_enable = 1;
        tick(); n_valid = 0;
        chk("nr.c3", 32'(n_count), 32'd3);
        chk("nr.b3", 32'(n_busy), 32'd1);
        tick(); chk("nr.c2", 32'(n_count), 32'd2);
        tick(); chk("nr.c1", 32'(n_count), 32'd1);
        chk("nr.tc1", 32'(n_tc), 32'd0);
        tick();
        chk("nr.c0", 32'(n_count), 32'd0);
        chk("nr.tc0", 32'(n_tc), 32'd1);
        chk("nr.b0", 32'(n_busy), 32'd1);
        chk("nr.exp0", 32'(n_expc), 32'd1);
        chk("nr.rdy_exp", 32'(n_ready), 32'd0);
        tick();
        chk("nr.idle.count", 32'(n_count), 32'd0);
        chk("nr.idle.tc", 32'(n_tc), 32'd0);
        chk("nr.idle.busy", 32'(n_busy), 32'd0);
        chk("nr.idle.exp", 32'(n_expc), 32'd1);
        chk("nr.idle.ready", 32'(n_ready), 32'd1);
        tick();
        chk("nr.idle2.count", 32'(n_count), 32'd0);
        chk("nr.idle2.tc", 32'(n_tc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
